// File: rtl/ncluster_frame_tx.sv
// ncluster_frame_tx: cluster-frame link transmitter (header, nturn data words, optional XOR trailer under NCLUSTER_TX_TRAILER_EN)
module ncluster_frame_tx #(
  parameter logic [12:0] MAX_NCLUSTER = 13'd8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] ncluster_in,
  input  logic [9:0]  user_in,
  input  logic [37:0] cl_data,
  input  logic        cl_valid,
  output logic        cl_ready,
  output logic [37:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_hdr,
  output logic [14:0] nturn_out,
  output logic        busy,
  output logic        done,
  output logic        err_clamp
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, TRAIL, DONE} state_t;
`ifdef NCLUSTER_TX_TRAILER_EN
  localparam state_t S_AFTER = TRAIL;
`else
  localparam state_t S_AFTER = DONE;
`endif
  state_t      r_state, w_state_nx;
  logic [12:0] r_n;
  logic [14:0] r_rem;
  logic [37:0] r_out_data;
  logic        r_out_valid, r_is_hdr, r_err;
  logic [13:0] w_diff;
  logic [12:0] w_n;
  logic        w_clamp, w_take, w_leave, w_fin;
`ifdef NCLUSTER_TX_TRAILER_EN
  logic [37:0] r_acc;
`endif
  // clamp by sign of MAX - request, avoiding a compare that is constant at the default MAX
  assign w_diff    = {1'b0, MAX_NCLUSTER} - {1'b0, ncluster_in};
  assign w_clamp   = w_diff[13];
  assign w_n       = w_clamp ? MAX_NCLUSTER : ncluster_in;
  assign cl_ready  = (r_state == DATA) && (r_rem != 15'd0) && (!r_out_valid || out_ready);
  assign w_take    = cl_valid && cl_ready;
  assign w_leave   = r_out_valid && out_ready;
  assign w_fin     = (r_rem == 15'd0) && (!r_out_valid || out_ready);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_is_hdr = r_is_hdr;
  assign nturn_out = r_is_hdr ? {r_n, 2'b00} : 15'd0;
  assign err_clamp = r_err;
  assign busy      = (r_state == HDR) || (r_state == DATA) || (r_state == TRAIL);
  assign done      = r_state == DONE;
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_state_nx;
  // frame sequencing: header, data until counter drains and the last word leaves, then trailer/done
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    w_state_nx = start ? HDR : IDLE;
      HDR:     w_state_nx = out_ready ? ((r_rem == 15'd0) ? S_AFTER : DATA) : HDR;
      DATA:    w_state_nx = w_fin ? S_AFTER : DATA;
      TRAIL:   w_state_nx = out_ready ? DONE : TRAIL;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end
  // output register: loads header on start, upstream words on accept, trailer on entry to TRAIL
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n         <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_is_hdr    <= 1'b0;
      r_err       <= 1'b0;
`ifdef NCLUSTER_TX_TRAILER_EN
      r_acc       <= '0;
`endif
    end else if (r_state == IDLE && start) begin
      r_n         <= w_n;
      r_rem       <= {w_n, 2'b00};
      r_err       <= r_err | w_clamp;
      r_out_data  <= {1'b0, 11'h7FF, user_in, 16'hAAAA};
      r_out_valid <= 1'b1;
      r_is_hdr    <= 1'b1;
`ifdef NCLUSTER_TX_TRAILER_EN
      r_acc       <= '0;
`endif
    end else if (w_take) begin
      r_rem       <= r_rem - 15'd1;
      r_out_data  <= cl_data;
      r_out_valid <= 1'b1;
      r_is_hdr    <= 1'b0;
`ifdef NCLUSTER_TX_TRAILER_EN
      r_acc       <= r_acc ^ cl_data;
    end else if (w_state_nx == TRAIL && r_state != TRAIL) begin
      r_out_data  <= r_acc;
      r_out_valid <= 1'b1;
      r_is_hdr    <= 1'b0;
`endif
    end else if (w_leave) begin
      r_out_valid <= 1'b0;
      r_is_hdr    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ncluster_frame_tx.sv
// tb_ncluster_frame_tx: scoreboard bench for ncluster_frame_tx (MAX_NCLUSTER=4)
module tb_ncluster_frame_tx;
  logic        clk = 0, rst = 1, start = 0, cl_valid = 0, out_ready = 1;
  logic [12:0] ncluster_in = 0;
  logic [9:0]  user_in = 0;
  logic [37:0] cl_data = 0;
  logic        cl_ready, out_valid, out_is_hdr, busy, done, err_clamp;
  logic [37:0] out_data;
  logic [14:0] nturn_out;
  typedef struct packed {logic hdr; logic [14:0] nt; logic [37:0] d;} exp_t;
  exp_t        exp_q[$];
  logic [37:0] cl_q[$];
  int total = 0, bad = 0, cyc = 0, last_fire_cyc = -10, done_cnt = 0, data_seen = 0, clr_hi = 0;
  int ready_mode = 0, bubble_en = 0;
  exp_t        mon_e;
  logic        stall_prev = 0, held_h;
  logic [37:0] held_d;
  logic [14:0] held_n;

  always #5 clk = ~clk;

  ncluster_frame_tx #(.MAX_NCLUSTER(13'd4)) dut (
    .clk(clk), .rst(rst), .start(start), .ncluster_in(ncluster_in), .user_in(user_in),
    .cl_data(cl_data), .cl_valid(cl_valid), .cl_ready(cl_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_hdr(out_is_hdr), .nturn_out(nturn_out), .busy(busy), .done(done), .err_clamp(err_clamp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: pops the scoreboard on every output handshake and checks stall/done rules
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) stall_prev = 0;
    else begin
      if (cl_ready) clr_hi++;
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held_d);
        chk("stall_hdr", out_is_hdr, held_h);
        chk("stall_nturn", nturn_out, held_n);
      end
      if (out_valid && !out_ready) chk("cl_ready_when_stalled", cl_ready, 0);
      if (!out_is_hdr) chk("nturn_zero", nturn_out, 0);
      if (done) begin
        done_cnt++;
        chk("done_after_last", cyc, last_fire_cyc + 1);
        chk("busy_at_done", busy, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word actual=%0h required=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word_data", out_data, mon_e.d);
          chk("word_hdr", out_is_hdr, mon_e.hdr);
          chk("word_nturn", nturn_out, mon_e.nt);
        end
        if (!out_is_hdr) data_seen++;
        last_fire_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      held_d = out_data;
      held_h = out_is_hdr;
      held_n = nturn_out;
    end
  end

  initial forever begin
    @(posedge clk);
    #1 out_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // upstream model: presents cl_q in order, optional random bubbles
  initial begin
    logic f;
    forever begin
      @(negedge clk);
      f = cl_valid && cl_ready;
      @(posedge clk);
      #1;
      if (f && cl_q.size() > 0) void'(cl_q.pop_front());
      if (cl_q.size() > 0 && !(bubble_en != 0 && $urandom_range(0, 2) == 0)) begin
        cl_valid = 1;
        cl_data = cl_q[0];
      end else cl_valid = 0;
    end
  end

  task automatic push_frame(input logic [9:0] u, input int neff, input bit pow, input logic [37:0] base);
    exp_t e;
    logic [37:0] w, acc;
    acc = 0;
    e.hdr = 1;
    e.nt = 15'(neff * 4);
    e.d = {1'b0, 11'h7FF, u, 16'hAAAA};
    exp_q.push_back(e);
    for (int i = 0; i < neff * 4; i++) begin
      w = pow ? (38'd1 << i) : base + 38'(i);
      acc ^= w;
      cl_q.push_back(w);
      e.hdr = 0;
      e.nt = 0;
      e.d = w;
      exp_q.push_back(e);
    end
`ifdef NCLUSTER_TX_TRAILER_EN
    e.hdr = 0;
    e.nt = 0;
    e.d = acc;
    exp_q.push_back(e);
`endif
  endtask

  task automatic issue_start(input logic [12:0] nreq, input logic [9:0] u);
    @(posedge clk);
    #1 start = 1;
    ncluster_in = nreq;
    user_in = u;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("first_valid", out_valid, 1);
    chk("first_is_hdr", out_is_hdr, 1);
    chk("busy_rise", busy, 1);
  endtask

  task automatic frame(input logic [12:0] nreq, input logic [9:0] u, input int neff,
                       input bit pow, input logic [37:0] base, input bit pester);
    int k;
    push_frame(u, neff, pow, base);
    issue_start(nreq, u);
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) break;
      start = pester && (k == 1 || k == 2);
      ncluster_in = 13'd2;
    end
    start = 0;
    chk("done_seen", done, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_is_hdr"}, out_is_hdr, 0);
    chk({tag, "_nturn"}, nturn_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_clamp, 0);
    chk({tag, "_cl_ready"}, cl_ready, 0);
  endtask

  initial begin
    int ds0, dc0, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 0;
    frame(13'd3, 10'h155, 3, 0, 38'd1, 0);
    clr_hi = 0;
    cl_q.push_back(38'h3A);
    frame(13'd0, 10'h0AA, 0, 0, 38'd0, 0);
    chk("n0_cl_ready_never", clr_hi, 0);
    chk("n0_no_word_taken", cl_q.size(), 1);
    cl_q.delete();
    ready_mode = 1;
    bubble_en = 1;
    frame(13'd2, 10'h2AA, 2, 0, 38'h100, 0);
    ready_mode = 0;
    bubble_en = 0;
    chk("err_before_clamp", err_clamp, 0);
    frame(13'd9, 10'h001, 4, 0, 38'h2000, 0);
    chk("err_after_clamp", err_clamp, 1);
    frame(13'd1, 10'h3FF, 1, 1, 38'd0, 1);
    chk("err_sticky", err_clamp, 1);
    push_frame(10'h123, 2, 0, 38'h5000);
    ds0 = data_seen;
    dc0 = done_cnt;
    issue_start(13'd2, 10'h123);
    for (k = 0; k < 500; k++) begin
      @(posedge clk);
      if (data_seen - ds0 >= 5) break;
    end
    chk("five_words_before_rst", (data_seen - ds0 >= 5), 1);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_all_zero("midrst");
    exp_q.delete();
    cl_q.delete();
    repeat (4) @(negedge clk);
    chk("no_done_after_rst", done_cnt, dc0);
    frame(13'd1, 10'h0F0, 1, 0, 38'h40, 0);
    chk("err_clear_after_rst", err_clamp, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
